// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default sizing for the matmul sequencer.
package matmul_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_OW      = 16;
    localparam int DEF_MAC_LAT = 3;
    localparam int IDX_W       = $clog2(DEF_N * DEF_N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/matmul_tag_pipe.sv
// matmul_tag_pipe: LAT-deep valid/index delay line that tracks MAC issues.
// Ports: clk, rst_n (async active-low clear), tag_in (pushed every cycle),
//        tag_out (oldest stage), occupied (any stage holds a valid tag).
module matmul_tag_pipe
    import matmul_pkg::*;
#(
    parameter int LAT = DEF_MAC_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic occupied
);

    tag_t st [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) st[k] <= '0;
        end else begin
            st[0] <= tag_in;
            for (int k = 1; k < LAT; k++) st[k] <= st[k-1];
        end
    end

    assign tag_out = st[LAT-1];

    always_comb begin
        occupied = 1'b0;
        for (int k = 0; k < LAT; k++) occupied = occupied | st[k].valid;
    end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences an N x N matrix multiply through an external MAC.
// Ports: clk, rst_n (async active-low); load_* byte-wide A/B write port with
//        load_ready; start/busy/done handshake; mac_in operands to the MAC and
//        mac_out result back; res_valid/res_idx/res_data realigned result
//        stream; cycles_last perf count.
// Build option: MATMUL_PERF_CNT_EN enables the busy-cycle counter behind
//        cycles_last; without it cycles_last is tied to 0.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int OW      = DEF_OW,
    parameter int MAC_LAT = DEF_MAC_LAT,
    localparam int IW     = $clog2(N * N),
    localparam int JW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    input  logic                load_sel,
    input  logic [IW-1:0]       load_addr,
    input  logic [DW-1:0]       load_data,
    output logic                load_ready,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [2*DW*N-1:0]   mac_in,
    input  logic [OW-1:0]       mac_out,
    output logic                res_valid,
    output logic [IW-1:0]       res_idx,
    output logic [OW-1:0]       res_data,
    output logic [15:0]         cycles_last
);

    state_t        state;
    logic [DW-1:0] a [N*N];
    logic [DW-1:0] b [N*N];
    logic [JW-1:0] i, j;
    logic [IW-1:0] cur;
    tag_t          iss, tag_out;
    logic          pipe_occ, fin;

    assign cur = IW'(int'(i) * N + int'(j));
    // Drain is complete once neither the issue register nor the pipe holds a tag.
    assign fin = state == DRAIN && !iss.valid && !pipe_occ;

    // iss is registered alongside mac_in, so the pipe delays it to line up
    // with mac_out exactly MAC_LAT edges after the operands were registered.
    matmul_tag_pipe #(.LAT(MAC_LAT)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_in   (iss),
        .tag_out  (tag_out),
        .occupied (pipe_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            iss        <= '0;
            mac_in     <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            for (int k = 0; k < N*N; k++) begin
                a[k] <= '0;
                b[k] <= '0;
            end
        end else begin
            done      <= 1'b0;
            res_valid <= tag_out.valid;
            if (tag_out.valid) begin
                res_idx  <= tag_out.idx;
                res_data <= mac_out;
            end
            if (load_valid && load_ready) begin
                if (load_sel) b[load_addr] <= load_data;
                else          a[load_addr] <= load_data;
            end
            case (state)
                IDLE: if (start) begin
                    state      <= RUN;
                    i          <= '0;
                    j          <= '0;
                    busy       <= 1'b1;
                    load_ready <= 1'b0;
                end
                RUN: begin
                    iss <= '{valid: 1'b1, idx: cur};
                    for (int k = 0; k < N; k++) begin
                        mac_in[2*DW*k +: DW]    <= a[IW'(int'(i) * N + k)];
                        mac_in[2*DW*k+DW +: DW] <= b[IW'(k * N + int'(j))];
                    end
                    j <= (j == JW'(N-1)) ? '0 : j + 1'b1;
                    if (j == JW'(N-1)) begin
                        i <= i + 1'b1;
                        if (i == JW'(N-1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    iss    <= '0;
                    mac_in <= '0;
                    if (fin) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATMUL_PERF_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            cycles_last <= '0;
        end else begin
            cnt <= (state == IDLE && start) ? '0 :
                   (busy && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
            if (fin) cycles_last <= cnt;
        end
    end
`else
    assign cycles_last = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed self-checking bench for matmul_sequencer with a MAC model.
module tb_matmul_sequencer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int LAT = 3;
    localparam int IW  = 4;
`ifdef MATMUL_PERF_CNT_EN
    localparam int PERF = 20;
`else
    localparam int PERF = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                load_valid = 1'b0;
    logic                load_sel = 1'b0;
    logic [IW-1:0]       load_addr = '0;
    logic [DW-1:0]       load_data = '0;
    logic                start = 1'b0;
    logic                load_ready, busy, done, res_valid;
    logic [2*DW*N-1:0]   mac_in;
    logic [OW-1:0]       mac_out, res_data;
    logic [IW-1:0]       res_idx;
    logic [15:0]         cycles_last;

    int errors = 0;
    int checks = 0;
    int ma [16];
    int mb [16];
    logic [2*DW*N-1:0] mp [LAT];

    matmul_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_sel    (load_sel),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mac_in      (mac_in),
        .mac_out     (mac_out),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .res_data    (res_data),
        .cycles_last (cycles_last)
    );

    always #5 clk = ~clk;

    // External MAC: result valid LAT edges after the operands were registered.
    always @(posedge clk) begin
        mp[0] <= mac_in;
        for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
    end

    always_comb begin
        mac_out = '0;
        for (int l = 0; l < N; l++)
            mac_out = mac_out + OW'(mp[LAT-1][16*l +: 8]) * OW'(mp[LAT-1][16*l+8 +: 8]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(int k);
        logic [63:0] p = '0;
        for (int l = 0; l < N; l++) begin
            p[16*l +: 8]   = 8'(ma[(k/4)*4 + l]);
            p[16*l+8 +: 8] = 8'(mb[l*4 + k%4]);
        end
        return p;
    endfunction

    function automatic logic [OW-1:0] cexp(int k);
        int s = 0;
        if (k > 15) return '0;
        for (int l = 0; l < N; l++) s += ma[(k/4)*4 + l] * mb[l*4 + k%4];
        return OW'(s);
    endfunction

    task automatic load(input logic sel, input int addr, input int data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = IW'(addr);
        load_data  = DW'(data);
        @(negedge clk);
        load_valid = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    // inj: 0 plain run, 1 start+load pulse mid-run, 2 reset at t0+8
    task automatic run(input int inj);
        int got = 0;
        int dones = 0;
        int first = -1;
        int last = -1;
        int done_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_t0", 64'(busy), 64'(1));
        for (int n = 1; n <= 30; n++) begin
            start      = (inj == 1 && n == 5);
            load_valid = (inj == 1 && n == 5);
            load_sel   = 1'b0;
            load_addr  = '0;
            load_data  = 8'd99;
            if (inj == 2 && n == 9) rst_n = 1'b1;
            @(negedge clk);
            if (inj == 2 && n == 8) begin
                rst_n = 1'b0;
                #1;
                chk("rst_load_ready", 64'(load_ready), 64'(1));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_res", {res_valid, res_idx, res_data}, 64'(0));
                chk("rst_cycles_last", 64'(cycles_last), 64'(0));
            end
            chk($sformatf("mac_in_c%0d", n), mac_in,
                (n <= 16 && !(inj == 2 && n >= 8)) ? pack(n - 1) : 64'(0));
            if (inj != 2 && n == 3) chk("load_ready_run", 64'(load_ready), 64'(0));
            if (res_valid) begin
                if (first < 0) first = n;
                last = n;
                chk($sformatf("res_idx_%0d", got), 64'(res_idx), 64'(got));
                chk($sformatf("res_data_%0d", got), 64'(res_data), 64'(cexp(got)));
                got++;
            end
            if (done) begin
                dones++;
                done_cyc = n;
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
        if (inj == 2) begin
            chk("rst_result_count", 64'(got), 64'(3));
            chk("rst_done_count", 64'(dones), 64'(0));
        end else begin
            chk("first_valid", 64'(first), 64'(5));
            chk("last_valid", 64'(last), 64'(20));
            chk("result_count", 64'(got), 64'(16));
            chk("done_cycle", 64'(done_cyc), 64'(21));
            chk("done_count", 64'(dones), 64'(1));
            chk("cycles_last", 64'(cycles_last), 64'(PERF));
            chk("load_ready_idle", 64'(load_ready), 64'(1));
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ma[k] = 0;
            mb[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_load_ready", 64'(load_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_res_valid", 64'(res_valid), 64'(0));
        chk("reset_mac_in", mac_in, 64'(0));
        chk("reset_res", {res_idx, res_data}, 64'(0));
        chk("reset_cycles_last", 64'(cycles_last), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, r*4 + c, (r == c) ? 1 : 0);
                load(1'b1, r*4 + c, r*4 + c);
            end
        run(0);

        for (int k = 0; k < 16; k++) begin
            load(1'b0, k, int'($urandom_range(0, 126)));
            load(1'b1, k, int'($urandom_range(0, 126)));
        end
        load(1'b0, 0, 5);
        run(0);

        run(1);
        run(0);

        run(2);
        for (int k = 0; k < 16; k++) begin
            ma[k] = 0;
            mb[k] = 0;
        end
        for (int k = 0; k < 16; k++) begin
            load(1'b0, k, 126);
            load(1'b1, k, 126);
        end
        run(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
